// File: rtl/cc_speed_pkg.sv
// Shared types and defaults for the speed time-base generator.
// Holds the FSM/pending encodings and the pending-request merge rule.
package cc_speed_pkg;

  localparam int unsigned        LEVEL_W   = 2;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd3;

  localparam int unsigned DEF_DATAWIDTH = 32;
  localparam int unsigned DEF_TIME_L0   = 40_000_000;
  localparam int unsigned DEF_TIME_L1   = 30_000_000;
  localparam int unsigned DEF_TIME_L2   = 20_000_000;
  localparam int unsigned DEF_TIME_L3   = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_UP,
    PEND_DOWN
  } pend_e;

  // Simultaneous up+down leaves the pending step untouched; an opposite request cancels it.
  function automatic pend_e merge_request(input pend_e cur, input logic up, input logic dn);
    pend_e res;
    res = cur;
    if (up && !dn) begin
      res = (cur == PEND_DOWN) ? PEND_NONE : PEND_UP;
    end else if (dn && !up) begin
      res = (cur == PEND_UP) ? PEND_NONE : PEND_DOWN;
    end
    return res;
  endfunction

endpackage

// File: rtl/cc_speed_counter_button.sv
// Push-button conditioner: 2-flop synchronizer, falling-edge detect,
// registered one-cycle pulse appearing 3 cycles after the pin falls.
module cc_button_edge
  import cc_speed_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, hist_q, pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      pulse_q <= hist_q & ~sync2_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cc_speed_counter.sv
// Speed time-base: counts 0..Time_cte, feeds the comparator buses, and
// steps the speed level (and its time constant) only on period boundaries.
module cc_speed_counter
  import cc_speed_pkg::*;
#(
  parameter int unsigned SPEEDCOUNTER_DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned SPEEDCOUNTER_TIME_L0   = DEF_TIME_L0,
  parameter int unsigned SPEEDCOUNTER_TIME_L1   = DEF_TIME_L1,
  parameter int unsigned SPEEDCOUNTER_TIME_L2   = DEF_TIME_L2,
  parameter int unsigned SPEEDCOUNTER_TIME_L3   = DEF_TIME_L3
) (
  input  logic                              CC_SPEEDCOUNTER_CLOCK_50,
  input  logic                              CC_SPEEDCOUNTER_RESET_InHigh,
  input  logic                              CC_SPEEDCOUNTER_enable_InHigh,
  input  logic                              CC_SPEEDCOUNTER_speedUp_InLow,
  input  logic                              CC_SPEEDCOUNTER_speedDown_InLow,
  output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
  output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_Time_cte_OutBUS,
  output logic [LEVEL_W-1:0]                CC_SPEEDCOUNTER_level_OutBUS,
  output logic                              CC_SPEEDCOUNTER_tick_OutHigh
);

  localparam int unsigned DW = SPEEDCOUNTER_DATAWIDTH;

  logic clk, rst, en;
  assign clk = CC_SPEEDCOUNTER_CLOCK_50;
  assign rst = CC_SPEEDCOUNTER_RESET_InHigh;
  assign en  = CC_SPEEDCOUNTER_enable_InHigh;

  logic up_req, dn_req;

  cc_button_edge u_btn_up (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_n_i (CC_SPEEDCOUNTER_speedUp_InLow),
    .pulse_o (up_req)
  );

  cc_button_edge u_btn_dn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_n_i (CC_SPEEDCOUNTER_speedDown_InLow),
    .pulse_o (dn_req)
  );

  function automatic logic [DW-1:0] level_time(input logic [LEVEL_W-1:0] lvl);
    logic [DW-1:0] t;
    case (lvl)
      2'd0:    t = DW'(SPEEDCOUNTER_TIME_L0);
      2'd1:    t = DW'(SPEEDCOUNTER_TIME_L1);
      2'd2:    t = DW'(SPEEDCOUNTER_TIME_L2);
      default: t = DW'(SPEEDCOUNTER_TIME_L3);
    endcase
    return t;
  endfunction

  state_e             state_q, state_d;
  logic [DW-1:0]      data_q, data_d;
  logic [DW-1:0]      tcte_q, tcte_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  pend_e              pend_q, pend_d, pend_eff;
  logic               tick_q, tick_d;
  logic               wrap, apply_step;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    level_d    = level_q;
    pend_eff   = merge_request(pend_q, up_req, dn_req);
    pend_d     = pend_eff;
    apply_step = 1'b0;
    wrap       = (data_q >= tcte_q);

    case (state_q)
      ST_IDLE: begin
        data_d     = '0;
        apply_step = 1'b1;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (en) begin
          if (wrap) begin
            data_d     = '0;
            apply_step = 1'b1;
          end else begin
            data_d = data_q + DW'(1);
          end
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (en) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // A step that would leave 0..3 is dropped, but the request is still consumed.
    if (apply_step) begin
      pend_d = PEND_NONE;
      if (pend_eff == PEND_UP && level_q != LEVEL_MAX) begin
        level_d = level_q + LEVEL_W'(1);
      end else if (pend_eff == PEND_DOWN && level_q != '0) begin
        level_d = level_q - LEVEL_W'(1);
      end
    end

    tcte_d = level_time(level_d);
    tick_d = (state_d == ST_RUN) && (data_d == tcte_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      level_q <= '0;
      tcte_q  <= level_time('0);
      pend_q  <= PEND_NONE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      level_q <= level_d;
      tcte_q  <= tcte_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

  assign CC_SPEEDCOUNTER_data_OutBUS     = data_q;
  assign CC_SPEEDCOUNTER_Time_cte_OutBUS = tcte_q;
  assign CC_SPEEDCOUNTER_level_OutBUS    = level_q;
  assign CC_SPEEDCOUNTER_tick_OutHigh    = tick_q;

endmodule
